// File: rtl/perf_pkg.sv
// Shared types and mp4 event-channel assignments for the performance counter bank.
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } perf_dump_state_e;

  // Channel numbers used when wiring mp4 event sources onto the bank.
  localparam int unsigned EV_L1I_SERVE  = 0;
  localparam int unsigned EV_L1I_MISS   = 1;
  localparam int unsigned EV_L1D_SERVE  = 2;
  localparam int unsigned EV_L1D_MISS   = 3;
  localparam int unsigned EV_L2_SERVE   = 4;
  localparam int unsigned EV_L2_MISS    = 5;
  localparam int unsigned EV_PMEM_RESP  = 6;
  localparam int unsigned EV_DATA_STALL = 7;
  localparam int unsigned EV_MEM_STALL  = 8;
  localparam int unsigned EV_CYCLE      = 9;
  localparam int unsigned EV_NUM_USED   = 10;

endpackage

// File: rtl/perf_counter_cell.sv
// One event channel: live counter with sticky overflow, plus a shadow register
// that captures the live value for a later dump.
module perf_counter_cell #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clear,
  input  logic                 capture,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 overflow
);

  logic [CNT_WIDTH-1:0] live;
  logic                 at_max_c;

  assign at_max_c = &live;

  // Clear wins over increment; at max either wrap or hold depending on SATURATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      live     <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (at_max_c) begin
        overflow <= 1'b1;
        if (SATURATE == 0) live <= '0;
      end else begin
        live <= live + CNT_WIDTH'(1);
      end
    end
  end

  // Shadow takes the pre-edge live value, so same-cycle events and clears miss it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= live;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with atomic snapshot and a valid/ready dump stream
// that walks the snapshot one channel per accepted beat.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned IDX_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  count_en,
  input  logic                  clear,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_W-1:0]      dump_idx,
  output logic [CNT_WIDTH-1:0]  dump_data,
  output logic                  dump_last,
  output logic [NUM_EVENTS-1:0] overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS - 1);

  perf_dump_state_e     state_q, state_d;
  logic [IDX_W-1:0]     idx_d;
  logic [IDX_W-1:0]     idx_inc_c;
  logic                 last_d;
  logic                 capture_c;
  logic [NUM_EVENTS-1:0] inc_c;
  logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];

  assign inc_c     = {NUM_EVENTS{count_en}} & events;
  assign idx_inc_c = dump_idx + IDX_W'(1);

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc_c[i]),
      .clear    (clear),
      .capture  (capture_c),
      .shadow   (shadow[i]),
      .overflow (overflow[i])
    );
  end

  // Next-state and next-index logic for the dump walker.
  always_comb begin
    state_d   = state_q;
    idx_d     = dump_idx;
    last_d    = dump_last;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d   = DUMP;
          idx_d     = '0;
          last_d    = 1'b0;
          capture_c = 1'b1;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (dump_last) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_inc_c;
            last_d = (idx_inc_c == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dump_idx   <= idx_d;
      dump_last  <= last_d;
      dump_valid <= (state_d == DUMP);
      busy       <= (state_d == DUMP);
    end
  end

  // Shadows and index are registers, both zero in reset, so data reads 0 then too.
  assign dump_data = shadow[dump_idx];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank: table-driven count vectors
// plus hand-written wrap/saturate, priority, backpressure and reset sequences.
module tb_perf_counter_bank;

  logic        clk;
  logic        rst;
  logic [15:0] events;
  logic        count_en;
  logic        clear;
  logic        snap_req;
  logic        dump_ready;

  logic        busy, dump_valid, dump_last;
  logic [3:0]  dump_idx;
  logic [31:0] dump_data;
  logic [15:0] overflow;

  logic        busy_w, valid_w, last_w;
  logic [1:0]  idx_w;
  logic [3:0]  data_w;
  logic [2:0]  ovf_w;

  logic        busy_s, valid_s, last_s;
  logic [1:0]  idx_s;
  logic [3:0]  data_s;
  logic [2:0]  ovf_s;

  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.NUM_EVENTS(16), .CNT_WIDTH(32), .SATURATE(0)) u_dut (
    .clk(clk), .rst(rst), .events(events), .count_en(count_en), .clear(clear),
    .snap_req(snap_req), .busy(busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last), .overflow(overflow)
  );

  perf_counter_bank #(.NUM_EVENTS(3), .CNT_WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .events(events[2:0]), .count_en(count_en), .clear(clear),
    .snap_req(snap_req), .busy(busy_w), .dump_valid(valid_w), .dump_ready(dump_ready),
    .dump_idx(idx_w), .dump_data(data_w), .dump_last(last_w), .overflow(ovf_w)
  );

  perf_counter_bank #(.NUM_EVENTS(3), .CNT_WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .events(events[2:0]), .count_en(count_en), .clear(clear),
    .snap_req(snap_req), .busy(busy_s), .dump_valid(valid_s), .dump_ready(dump_ready),
    .dump_idx(idx_s), .dump_data(data_s), .dump_last(last_s), .overflow(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ev;
    logic        en;
    int          ncyc;
    logic [31:0] val;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot then walk all 16 beats with ready high; channels in mask expect val.
  task automatic dump_check(input string tag, input logic [15:0] mask, input logic [31:0] val,
                            input logic with_clear, input logic [15:0] snap_ev);
    snap_req   = 1'b1;
    clear      = with_clear;
    events     = snap_ev;
    dump_ready = 1'b1;
    step();
    snap_req = 1'b0;
    clear    = 1'b0;
    events   = '0;
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("%s valid b%0d", tag, b), 64'(dump_valid), 64'(1));
      chk($sformatf("%s busy b%0d", tag, b), 64'(busy), 64'(1));
      chk($sformatf("%s idx b%0d", tag, b), 64'(dump_idx), 64'(b));
      chk($sformatf("%s data b%0d", tag, b), 64'(dump_data), mask[b] ? 64'(val) : 64'(0));
      chk($sformatf("%s last b%0d", tag, b), 64'(dump_last), 64'(b == 15));
      step();
    end
    chk($sformatf("%s end valid", tag), 64'(dump_valid), 64'(0));
    chk($sformatf("%s end busy", tag), 64'(busy), 64'(0));
  endtask

  initial begin
    int b;
    int cyc;
    logic acc;

    rst = 1'b0; events = '0; count_en = 1'b0; clear = 1'b0;
    snap_req = 1'b0; dump_ready = 1'b0;

    vecs[0] = '{ev: 16'h0008, en: 1'b1, ncyc: 5,  val: 32'd5};
    vecs[1] = '{ev: 16'hFFFF, en: 1'b0, ncyc: 10, val: 32'd0};
    vecs[2] = '{ev: 16'h8001, en: 1'b1, ncyc: 7,  val: 32'd7};
    vecs[3] = '{ev: 16'hAAAA, en: 1'b1, ncyc: 3,  val: 32'd3};
    vecs[4] = '{ev: 16'h0000, en: 1'b1, ncyc: 4,  val: 32'd0};

    #3;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst valid", 64'(dump_valid), 64'(0));
    chk("rst idx", 64'(dump_idx), 64'(0));
    chk("rst data", 64'(dump_data), 64'(0));
    chk("rst last", 64'(dump_last), 64'(0));
    chk("rst ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Table-driven count vectors, each followed by a full dump.
    for (int i = 0; i < 5; i++) begin
      clear = 1'b1;
      step();
      clear    = 1'b0;
      events   = vecs[i].ev;
      count_en = vecs[i].en;
      repeat (vecs[i].ncyc) step();
      events   = '0;
      count_en = 1'b1;
      dump_check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].val, 1'b0, 16'h0000);
      chk($sformatf("vec%0d ovf", i), 64'(overflow), 64'(0));
    end

    // Wrap versus saturate on 4-bit, 3-channel banks.
    clear = 1'b1;
    step();
    clear  = 1'b0;
    events = 16'h0001;
    repeat (17) step();
    events = '0;
    chk("wrap ovf", 64'(ovf_w), 64'(3'b001));
    chk("sat ovf", 64'(ovf_s), 64'(3'b001));
    snap_req   = 1'b1;
    dump_ready = 1'b1;
    step();
    snap_req = 1'b0;
    chk("wrap valid", 64'(valid_w), 64'(1));
    chk("wrap data0", 64'(data_w), 64'(1));
    chk("sat data0", 64'(data_s), 64'(15));
    chk("sat idx0", 64'(idx_s), 64'(0));
    step();
    chk("wrap idx1", 64'(idx_w), 64'(1));
    chk("wrap last1", 64'(last_w), 64'(0));
    step();
    chk("wrap idx2", 64'(idx_w), 64'(2));
    chk("wrap last2", 64'(last_w), 64'(1));
    chk("sat last2", 64'(last_s), 64'(1));
    step();
    chk("wrap done valid", 64'(valid_w), 64'(0));
    chk("sat done busy", 64'(busy_s), 64'(0));
    chk("wrap idx back", 64'(idx_w), 64'(0));
    repeat (14) step();
    chk("main drained", 64'(busy), 64'(0));

    // Clear beats a same-cycle event.
    clear  = 1'b1;
    events = 16'h0004;
    step();
    clear  = 1'b0;
    events = '0;
    chk("clr ovf", 64'(ovf_w), 64'(0));
    dump_check("clrpri", 16'h0000, 32'd0, 1'b0, 16'h0000);

    // Snapshot with clear takes pre-clear values; snapshot-cycle event counts live only.
    events = 16'h0002;
    repeat (7) step();
    events = '0;
    dump_check("snapclr", 16'h0002, 32'd7, 1'b1, 16'h0000);
    dump_check("snapev", 16'h0000, 32'd0, 1'b0, 16'h0010);
    dump_check("afterev", 16'h0010, 32'd1, 1'b0, 16'h0000);

    // Backpressure with ready pattern 1,0,0 and an ignored mid-dump snap_req.
    clear = 1'b1;
    step();
    clear  = 1'b0;
    events = 16'h00F0;
    repeat (2) step();
    events   = '0;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    b   = 0;
    cyc = 0;
    while (b < 16 && cyc < 200) begin
      chk($sformatf("bp valid c%0d", cyc), 64'(dump_valid), 64'(1));
      chk($sformatf("bp idx c%0d", cyc), 64'(dump_idx), 64'(b));
      chk($sformatf("bp data c%0d", cyc), 64'(dump_data), (b >= 4 && b <= 7) ? 64'(2) : 64'(0));
      chk($sformatf("bp last c%0d", cyc), 64'(dump_last), 64'(b == 15));
      dump_ready = (cyc % 3 == 0);
      if (cyc == 4) begin
        snap_req = 1'b1;
        events   = 16'hFFFF;
      end else begin
        snap_req = 1'b0;
        events   = '0;
      end
      acc = dump_ready;
      step();
      if (acc) b++;
      cyc++;
    end
    snap_req = 1'b0;
    events   = '0;
    chk("bp beats", 64'(b), 64'(16));
    chk("bp end valid", 64'(dump_valid), 64'(0));

    // Async reset in the middle of a dump; counters now hold 3 on ch4..7, 1 elsewhere.
    dump_ready = 1'b1;
    snap_req   = 1'b1;
    step();
    snap_req = 1'b0;
    repeat (5) step();
    chk("mid idx", 64'(dump_idx), 64'(5));
    chk("mid data", 64'(dump_data), 64'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("arst valid", 64'(dump_valid), 64'(0));
    chk("arst busy", 64'(busy), 64'(0));
    chk("arst idx", 64'(dump_idx), 64'(0));
    chk("arst data", 64'(dump_data), 64'(0));
    chk("arst last", 64'(dump_last), 64'(0));
    chk("arst ovf", 64'(overflow), 64'(0));
    chk("arst small valid", 64'(valid_w), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    dump_check("postrst", 16'h0000, 32'd0, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable bank of parametrised hardware event counters for the mp4 core and cache hierarchy. It counts per-cycle event pulses such as cache serves and misses, pmem responses, data and memory stalls, and total cycles. On request it snapshots every counter atomically and streams the snapshot out over a valid/ready dump port. It sits beside `i_cache_top` and `i_datapath` inside `mp4`, so counts come from hardware rather than bench-only `always` blocks.

## Interface
- `NUM_EVENTS`, default 16: number of counter channels; must be ≥ 2.
- `CNT_WIDTH`, default 32: width of each counter; must be ≥ 2.
- `SATURATE`, default 0: 0 means counters wrap at max; 1 means counters hold at all-ones.
- `IDX_W`, default `$clog2(NUM_EVENTS)`: channel index width; derived, not overridden.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-low. Asserted when 0.
- `events`, in, `NUM_EVENTS`: bit i high adds 1 to counter i at the edge.
- `count_en`, in, 1: global count enable; when 0 all events are ignored.
- `clear`, in, 1: synchronous clear of all live counters and overflow flags.
- `snap_req`, in, 1: pulse that captures all live counters and starts a dump.
- `busy`, out, 1: high while a dump is in progress.
- `dump_valid`, out, 1: `dump_data` and `dump_idx` are valid.
- `dump_ready`, in, 1: consumer accepts the current dump beat.
- `dump_idx`, out, `IDX_W`: channel number of the current beat.
- `dump_data`, out, `CNT_WIDTH`: snapshot value of channel `dump_idx`.
- `dump_last`, out, 1: high on the beat where `dump_idx == NUM_EVENTS-1`.
- `overflow`, out, `NUM_EVENTS`: sticky per-channel overflow flags (live, not snapshotted).

## Operation
Live counters:
- Counter i is incremented when `count_en & events[i] & !clear`.
- At max value with `SATURATE=0`, the counter wraps to 0 and sets `overflow[i]`.
- At max value with `SATURATE=1`, the counter stays at all-ones and sets `overflow[i]`.
- `overflow[i]` stays set until `clear` or reset.
- `clear` has priority over increment: the counter reads 0 after the edge, even if its event is high.

Snapshot:
- Snapshot registers load from the live counters' pre-edge values on an accepted `snap_req`.
- An event in the same cycle as the snapshot is counted live but is not in the snapshot.
- `clear` and `snap_req` in the same cycle: the snapshot takes the pre-clear values, then the live counters clear.

FSM, states IDLE and DUMP:
- IDLE to DUMP on `snap_req`. The edge loads the snapshot and sets `dump_idx` to 0.
- In DUMP, `dump_valid` = 1 and `busy` = 1.
- A beat is accepted when `dump_valid & dump_ready`.
- On acceptance with `dump_idx == NUM_EVENTS-1`, go to IDLE and reset `dump_idx` to 0.
- On any other acceptance, increment `dump_idx`.
- `snap_req` while in DUMP is ignored: no re-capture and no restart.
- `clear` during DUMP affects only the live counters; the shadow registers are untouched.
- `dump_data` is driven from the shadow register indexed by `dump_idx`.

## Timing
- On `rst` assertion, asynchronously and immediately:
  - all live counters, shadow registers and `overflow` go to 0;
  - state goes to IDLE;
  - `busy`, `dump_valid`, `dump_last`, `dump_idx` and `dump_data` all read 0.
- A reset mid-dump aborts the dump; no partial-beat obligation remains.
- Increment latency is 1 edge: an event sampled at edge k is visible on the counter after edge k.
- `snap_req` high at edge k means `dump_valid`, `busy`, `dump_idx`=0 and `dump_data`=snapshot[0] are all valid after edge k.
- `dump_data`, `dump_idx` and `dump_last` hold stable while `dump_valid & !dump_ready`.
- With `dump_ready` tied high, a full dump takes exactly `NUM_EVENTS` cycles.
- `busy` falls on the edge that accepts the last beat.
- A new `snap_req` is honoured on the first cycle `busy` = 0, i.e. the cycle right after the last beat.
- The dump index has no wrap-around beyond `NUM_EVENTS-1`, including for non-power-of-two `NUM_EVENTS`.

## Structure
- The package `perf_pkg` holds:
  - the `perf_dump_state_e` enum (IDLE, DUMP);
  - the localparam event-index constants for mp4 wiring, such as `EV_L1I_SERVE`, `EV_L1D_MISS`, `EV_L2_MISS`, `EV_PMEM_RESP`, `EV_DATA_STALL`, `EV_MEM_STALL` and `EV_CYCLE`.
- Sub-module `perf_counter_cell` (params `CNT_WIDTH`, `SATURATE`) is generated `NUM_EVENTS` times.
  - It holds one live counter, its overflow flag, and its shadow register with a capture input.
- The FSM, index counter and output mux sit in the top of `perf_counter_bank`.

## Test plan
1. Pulse and basic count: reset, hold `count_en`=1, pulse `events[3]` for 5 cycles, then `snap_req` with `dump_ready`=1 → 16 beats, beat 3 carries 5, all other beats carry 0, and `dump_last` is high only on idx 15.
2. Wrap versus saturate: `CNT_WIDTH`=4, hold `events[0]` for 17 cycles → `SATURATE=0` reads 1 with `overflow[0]`=1; `SATURATE=1` reads 15 with `overflow[0]`=1.
3. Same-cycle priority:
   - `clear` with `events[2]` high leaves counter 2 at 0;
   - `snap_req` with `clear` and counter 1 at 7 gives dump beat 1 = 7 and live counter 1 = 0.
4. Backpressure: drive `dump_ready` = 1,0,0,1,… → `dump_data`/`dump_idx` stay stable during the low cycles, every index 0..15 appears exactly once in order, and a `snap_req` mid-dump does not change the values.
5. Async reset mid-dump: drop `rst` to 0 at beat 5 between clock edges → `dump_valid`, `busy` and all counters go to 0 immediately; after release a fresh snapshot dumps all zeros.
6. `count_en`=0 while `events` is all ones for 10 cycles → all snapshot values are 0 and no overflow flag is set.
